// File: rtl/window_scan_controller_if.sv
// ---------------------------------------------------------------------------
// window_scan_controller_if
// Pixel-stream, window-buffer and window-handshake signals of the window scan
// controller.
//   pixel_valid/pixel_data/pixel_ready : upstream pixel stream
//   buf_enable/buf_data                : shift port into the window buffer
//   win_ready/win_valid/win_x/win_y    : scheduled-window handshake
// modport master : the controller side
// modport slave  : the environment side (pixel source, buffer, window sink)
// ---------------------------------------------------------------------------
interface window_scan_controller_if #(
    parameter int unsigned bitwidth = 8,
    parameter int unsigned xw       = 10,
    parameter int unsigned yw       = 10
);
    logic                pixel_valid;
    logic [bitwidth-1:0] pixel_data;
    logic                pixel_ready;
    logic                buf_enable;
    logic [bitwidth-1:0] buf_data;
    logic                win_ready;
    logic                win_valid;
    logic [xw-1:0]       win_x;
    logic [yw-1:0]       win_y;

    modport master (
        input  pixel_valid, pixel_data, win_ready,
        output pixel_ready, buf_enable, buf_data, win_valid, win_x, win_y
    );

    modport slave (
        output pixel_valid, pixel_data, win_ready,
        input  pixel_ready, buf_enable, buf_data, win_valid, win_x, win_y
    );
endinterface

// File: rtl/window_scan_controller.sv
// ---------------------------------------------------------------------------
// window_scan_controller
// Raster-scans an imCol x imRow image arriving one pixel per accept, feeds
// every accepted pixel into an external sliding window buffer, and flags each
// window position (top-left win_x, win_y) on the given stride once the buffer
// holds that window.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   frame_start       : one-cycle start-of-frame pulse (honoured only in IDLE)
//   bus (master)      : pixel stream in, buffer shift port out, window handshake
//   win_count         : windows issued this frame (wraps modulo 2^20)
//   busy              : controller not idle
//   frame_done        : one-cycle pulse when the frame has fully drained
// ---------------------------------------------------------------------------
module window_scan_controller #(
    parameter int unsigned imCol    = 1024,
    parameter int unsigned imRow    = 768,
    parameter int unsigned winRow   = 24,
    parameter int unsigned winCol   = 24,
    parameter int unsigned bitwidth = 8,
    parameter int unsigned step     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    frame_start,
    window_scan_controller_if.master bus,
    output logic [19:0]             win_count,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int unsigned XW = (imCol > 1) ? $clog2(imCol) : 1;
    localparam int unsigned YW = (imRow > 1) ? $clog2(imRow) : 1;
    localparam int unsigned SW = (step > 1) ? $clog2(step) : 1;

    localparam logic [XW-1:0] COL_LAST      = XW'(imCol - 1);
    localparam logic [XW-1:0] COL_WIN       = XW'(winCol - 1);
    localparam logic [YW-1:0] ROW_LAST      = YW'(imRow - 1);
    localparam logic [YW-1:0] ROW_WIN       = YW'(winRow - 1);
    localparam logic [YW-1:0] ROW_FILL_LAST = YW'(winRow - 2);
    localparam logic [SW-1:0] STEP_LAST     = SW'(step - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] SCAN  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic [SW-1:0] sx_q, sx_d;
    logic [SW-1:0] sy_q, sy_d;
    logic          win_valid_q, win_valid_d;
    logic [XW-1:0] win_x_q, win_x_d;
    logic [YW-1:0] win_y_q, win_y_d;
    logic [19:0]   win_count_q, win_count_d;
    logic          frame_done_q, frame_done_d;

    logic ready;
    logic accept;
    logic sched;
    logic last_col;
    logic last_row;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        win_valid_d  = win_valid_q;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        win_count_d  = win_count_q;
        frame_done_d = 1'b0;

        last_col = (col_q == COL_LAST);
        last_row = (row_q == ROW_LAST);
        // A stalled window blocks new pixels, which freezes the buffer contents.
        ready    = ((state_q == FILL) || (state_q == SCAN)) &&
                   !(win_valid_q && !bus.win_ready);
        accept   = bus.pixel_valid && ready;
        sched    = accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN) &&
                   (sx_q == '0) && (sy_q == '0);

        // Position and stride counters; sx/sy are (pos - (win-1)) mod step,
        // re-phased to zero when the position reaches the first window column/row.
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
                if (row_d == ROW_WIN) begin
                    sy_d = '0;
                end else begin
                    sy_d = (sy_q == STEP_LAST) ? '0 : sy_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
            if (col_d == COL_WIN) begin
                sx_d = '0;
            end else begin
                sx_d = (sx_q == STEP_LAST) ? '0 : sx_q + 1'b1;
            end
        end

        // Set wins over the consume-clear so back-to-back windows never drop.
        if (sched) begin
            win_valid_d = 1'b1;
            win_x_d     = col_q - COL_WIN;
            win_y_d     = row_q - ROW_WIN;
            win_count_d = win_count_q + 20'd1;
        end else if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d     = FILL;
                    col_d       = '0;
                    row_d       = '0;
                    sx_d        = '0;
                    sy_d        = '0;
                    win_count_d = '0;
                end
            end
            FILL: begin
                if (accept && last_col) begin
                    if (last_row) begin
                        state_d = DRAIN;
                    end else if (row_q == ROW_FILL_LAST) begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (accept && last_col && last_row) begin
                    state_d = DRAIN;
                end
            end
            default: begin
                if (!win_valid_q || bus.win_ready) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            win_valid_q  <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            win_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            win_valid_q  <= win_valid_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            win_count_q  <= win_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pixel_ready = ready;
    assign bus.buf_enable  = accept;
    assign bus.buf_data    = bus.pixel_data;
    assign bus.win_valid   = win_valid_q;
    assign bus.win_x       = win_x_q;
    assign bus.win_y       = win_y_q;
    assign win_count       = win_count_q;
    assign busy            = (state_q != IDLE);
    assign frame_done      = frame_done_q;
endmodule

// File: tb/tb_window_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_window_scan_controller
// Directed bench for window_scan_controller on an 8x6 image with 3x3 windows.
// Instance a uses stride 1, instance b stride 2; both see the same pixel
// stream and window-ready. A reference window buffer is shifted by a's
// buf_enable/buf_data and compared against the image at (win_x, win_y).
// ---------------------------------------------------------------------------
module tb_window_scan_controller;
    localparam int IMC    = 8;
    localparam int IMR    = 6;
    localparam int WR     = 3;
    localparam int WC     = 3;
    localparam int BW     = 8;
    localparam int XW     = 3;
    localparam int YW     = 3;
    localparam int BUFLEN = (WR - 1) * IMC + WC;

    logic          clock = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          pv;
    logic          wr;
    logic [BW-1:0] pd;
    logic [19:0]   win_count_a, win_count_b;
    logic          busy_a, busy_b, fd_a, fd_b;

    int checks = 0;
    int errors = 0;

    window_scan_controller_if #(.bitwidth(BW), .xw(XW), .yw(YW)) bus_a ();
    window_scan_controller_if #(.bitwidth(BW), .xw(XW), .yw(YW)) bus_b ();

    assign bus_a.pixel_valid = pv;
    assign bus_a.pixel_data  = pd;
    assign bus_a.win_ready   = wr;
    assign bus_b.pixel_valid = pv;
    assign bus_b.pixel_data  = pd;
    assign bus_b.win_ready   = wr;

    window_scan_controller #(
        .imCol(IMC), .imRow(IMR), .winRow(WR), .winCol(WC), .bitwidth(BW), .step(1)
    ) dut_a (
        .clock(clock), .reset(reset), .frame_start(frame_start), .bus(bus_a),
        .win_count(win_count_a), .busy(busy_a), .frame_done(fd_a)
    );

    window_scan_controller #(
        .imCol(IMC), .imRow(IMR), .winRow(WR), .winCol(WC), .bitwidth(BW), .step(2)
    ) dut_b (
        .clock(clock), .reset(reset), .frame_start(frame_start), .bus(bus_b),
        .win_count(win_count_b), .busy(busy_b), .frame_done(fd_b)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] pix_val(input int idx);
        return 8'((idx * 37 + 11) & 255);
    endfunction

    // Bookkeeping on the falling edge: inputs and outputs are stable there.
    int          frame_acc     = 0;
    int          hs_a          = 0;
    int          wv_cycles_a   = 0;
    int          bad_win       = 0;
    int          bad_buf       = 0;
    int          fd_cnt_a      = 0;
    int          fd_cnt_b      = 0;
    int          first_win_acc = -1;
    bit          seen_win      = 1'b0;
    int          qx_a[$], qy_a[$], qx_b[$], qy_b[$];
    logic [7:0]  bufm [BUFLEN];

    assign pd = pix_val(frame_acc);

    always @(negedge clock) begin
        int  wx, wy;
        bit  ok;
        if (frame_start && !busy_a && !reset) begin
            frame_acc = 0;
            seen_win  = 1'b0;
        end
        if (bus_a.win_valid) begin
            if (!seen_win) begin
                seen_win      = 1'b1;
                first_win_acc = frame_acc;
            end
            wv_cycles_a++;
            wx = int'(bus_a.win_x);
            wy = int'(bus_a.win_y);
            ok = 1'b1;
            for (int dy = 0; dy < WR; dy++)
                for (int dx = 0; dx < WC; dx++)
                    if (bufm[(WR - 1 - dy) * IMC + (WC - 1 - dx)] !==
                        pix_val((wy + dy) * IMC + wx + dx))
                        ok = 1'b0;
            if (!ok) bad_win++;
            if (wr) begin
                hs_a++;
                qx_a.push_back(wx);
                qy_a.push_back(wy);
            end
        end
        if (bus_b.win_valid && wr) begin
            qx_b.push_back(int'(bus_b.win_x));
            qy_b.push_back(int'(bus_b.win_y));
        end
        if (fd_a) fd_cnt_a++;
        if (fd_b) fd_cnt_b++;
        if ((bus_a.buf_enable !== (pv && bus_a.pixel_ready)) ||
            (bus_a.buf_enable && (bus_a.buf_data !== pd)))
            bad_buf++;
        if (bus_a.buf_enable) begin
            for (int i = BUFLEN - 1; i > 0; i--) bufm[i] = bufm[i - 1];
            bufm[0] = bus_a.buf_data;
            frame_acc++;
        end
    end

    // Mismatches between recorded stride-1 windows from base and raster order.
    function automatic int order_errors(input int base);
        int n = 0;
        for (int i = 0; i < 24; i++) begin
            if (base + i >= qx_a.size()) n++;
            else if (qx_a[base + i] != i % 6 || qy_a[base + i] != i / 6) n++;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_frame_start();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_start = 1'b0; pv = 1'b1; wr = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_a); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %0b want 0", busy_b); end
        checks++; if (bus_a.win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got %0b want 0", bus_a.win_valid); end
        checks++; if (win_count_a !== 20'd0) begin errors++; $display("FAIL reset_win_count got %0d want 0", win_count_a); end
        checks++; if (bus_a.pixel_ready !== 1'b0) begin errors++; $display("FAIL reset_pixel_ready got %0b want 0", bus_a.pixel_ready); end
        checks++; if (bus_a.buf_enable !== 1'b0) begin errors++; $display("FAIL reset_buf_enable got %0b want 0", bus_a.buf_enable); end
        checks++; if (fd_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b want 0", fd_a); end
        checks++; if (bus_a.win_x !== 3'd0 || bus_a.win_y !== 3'd0) begin errors++; $display("FAIL reset_win_xy got (%0d,%0d) want (0,0)", bus_a.win_x, bus_a.win_y); end
        tick();
        reset = 1'b0; pv = 1'b0;
        tick();
    endtask

    task automatic wait_frame_done(input int budget, input string name);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clock);
            if (fd_a) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout got no frame_done want frame_done within %0d cycles", name, budget);
        end
    endtask

    task automatic test_stride_one_two();
        int h0 = hs_a, q0 = qx_a.size(), qb0 = qx_b.size(), wv0 = wv_cycles_a;
        int fa0 = fd_cnt_a, fb0 = fd_cnt_b, bw0 = bad_win, bb0 = bad_buf;
        int xb[6] = '{0, 2, 4, 0, 2, 4};
        int yb[6] = '{0, 0, 0, 2, 2, 2};
        int nb = 0;
        wr = 1'b1; pv = 1'b1;
        pulse_frame_start();
        wait_frame_done(200, "stride1");
        repeat (3) @(negedge clock);
        checks++; if (hs_a - h0 != 24) begin errors++; $display("FAIL s1_windows got %0d want 24", hs_a - h0); end
        checks++; if (wv_cycles_a - wv0 != 24) begin errors++; $display("FAIL s1_valid_cycles got %0d want 24", wv_cycles_a - wv0); end
        checks++; if (first_win_acc != 19) begin errors++; $display("FAIL s1_first_latency got %0d want 19", first_win_acc); end
        checks++; if (order_errors(q0) != 0) begin errors++; $display("FAIL s1_order got %0d bad want 0", order_errors(q0)); end
        if (qx_a.size() >= q0 + 24) begin
            checks++; if (qx_a[q0] != 0 || qy_a[q0] != 0) begin errors++; $display("FAIL s1_first_xy got (%0d,%0d) want (0,0)", qx_a[q0], qy_a[q0]); end
            checks++; if (qx_a[q0 + 23] != 5 || qy_a[q0 + 23] != 3) begin errors++; $display("FAIL s1_last_xy got (%0d,%0d) want (5,3)", qx_a[q0 + 23], qy_a[q0 + 23]); end
        end
        checks++; if (win_count_a !== 20'd24) begin errors++; $display("FAIL s1_win_count got %0d want 24", win_count_a); end
        checks++; if (fd_cnt_a - fa0 != 1) begin errors++; $display("FAIL s1_frame_done got %0d want 1", fd_cnt_a - fa0); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL s1_busy_after got %0b want 0", busy_a); end
        checks++; if (bad_win - bw0 != 0) begin errors++; $display("FAIL s1_window_content got %0d bad want 0", bad_win - bw0); end
        checks++; if (bad_buf - bb0 != 0) begin errors++; $display("FAIL s1_buf_port got %0d bad want 0", bad_buf - bb0); end
        checks++; if (qx_b.size() - qb0 != 6) begin errors++; $display("FAIL s2_windows got %0d want 6", qx_b.size() - qb0); end
        for (int i = 0; i < 6; i++)
            if (qb0 + i < qx_b.size() && (qx_b[qb0 + i] != xb[i] || qy_b[qb0 + i] != yb[i])) nb++;
        checks++; if (nb != 0) begin errors++; $display("FAIL s2_positions got %0d bad want 0", nb); end
        checks++; if (win_count_b !== 20'd6) begin errors++; $display("FAIL s2_win_count got %0d want 6", win_count_b); end
        checks++; if (fd_cnt_b - fb0 != 1) begin errors++; $display("FAIL s2_frame_done got %0d want 1", fd_cnt_b - fb0); end
    endtask

    task automatic test_backpressure();
        int h0 = hs_a, q0 = qx_a.size(), bw0 = bad_win, bb0 = bad_buf;
        bit found = 1'b0;
        wr = 1'b0; pv = 1'b1;
        pulse_frame_start();
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clock);
            if (bus_a.win_valid) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL bp_first_window got none want win_valid within 100 cycles"); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            checks++; if (bus_a.pixel_ready !== 1'b0 || bus_a.buf_enable !== 1'b0) begin errors++; $display("FAIL bp_stall_%0d got ready=%0b en=%0b want 0 0", k, bus_a.pixel_ready, bus_a.buf_enable); end
            checks++; if (bus_a.win_valid !== 1'b1 || bus_a.win_x !== 3'd0 || bus_a.win_y !== 3'd0) begin errors++; $display("FAIL bp_hold_%0d got v=%0b (%0d,%0d) want 1 (0,0)", k, bus_a.win_valid, bus_a.win_x, bus_a.win_y); end
        end
        tick();
        wr = 1'b1;
        wait_frame_done(200, "bp");
        @(negedge clock);
        checks++; if (hs_a - h0 != 24) begin errors++; $display("FAIL bp_windows got %0d want 24", hs_a - h0); end
        checks++; if (order_errors(q0) != 0) begin errors++; $display("FAIL bp_order got %0d bad want 0", order_errors(q0)); end
        checks++; if (win_count_a !== 20'd24) begin errors++; $display("FAIL bp_win_count got %0d want 24", win_count_a); end
        checks++; if (bad_win - bw0 != 0 || bad_buf - bb0 != 0) begin errors++; $display("FAIL bp_content got %0d/%0d bad want 0/0", bad_win - bw0, bad_buf - bb0); end
    endtask

    task automatic test_ignored_inputs();
        int h0 = hs_a, bw0 = bad_win;
        bit reached = 1'b0;
        wr = 1'b1; pv = 1'b1;
        pulse_frame_start();
        for (int n = 0; n < 100 && !reached; n++) begin
            @(negedge clock);
            if (frame_acc >= 30) reached = 1'b1;
        end
        checks++; if (!reached) begin errors++; $display("FAIL ign_reach_scan got %0d accepts want 30", frame_acc); end
        pulse_frame_start();
        @(negedge clock);
        checks++; if (busy_a !== 1'b1 || win_count_a < 20'd12) begin errors++; $display("FAIL ign_midframe got busy=%0b count=%0d want 1 >=12", busy_a, win_count_a); end
        wait_frame_done(200, "ign");
        checks++; if (frame_acc != IMC * IMR) begin errors++; $display("FAIL ign_accepts got %0d want %0d", frame_acc, IMC * IMR); end
        checks++; if (hs_a - h0 != 24 || win_count_a !== 20'd24) begin errors++; $display("FAIL ign_windows got %0d/%0d want 24/24", hs_a - h0, win_count_a); end
        checks++; if (bad_win - bw0 != 0) begin errors++; $display("FAIL ign_content got %0d bad want 0", bad_win - bw0); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++; if (bus_a.pixel_ready !== 1'b0 || bus_a.buf_enable !== 1'b0 || busy_a !== 1'b0 || win_count_a !== 20'd24) begin
                errors++; $display("FAIL ign_idle_%0d got ready=%0b en=%0b busy=%0b count=%0d want 0 0 0 24", k, bus_a.pixel_ready, bus_a.buf_enable, busy_a, win_count_a);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int h0, q0, bw0;
        bit reached = 1'b0;
        wr = 1'b1; pv = 1'b1;
        pulse_frame_start();
        for (int n = 0; n < 100 && !reached; n++) begin
            @(negedge clock);
            if (frame_acc >= 30) reached = 1'b1;
        end
        checks++; if (!reached) begin errors++; $display("FAIL rst_reach got %0d accepts want 30", frame_acc); end
        tick();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++; if (busy_a !== 1'b0 || bus_a.win_valid !== 1'b0 || win_count_a !== 20'd0) begin errors++; $display("FAIL rst_state got busy=%0b v=%0b count=%0d want 0 0 0", busy_a, bus_a.win_valid, win_count_a); end
        checks++; if (bus_a.pixel_ready !== 1'b0 || bus_a.buf_enable !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b/%0b want 0/0", bus_a.pixel_ready, bus_a.buf_enable); end
        tick();
        reset = 1'b0;
        h0 = hs_a; q0 = qx_a.size(); bw0 = bad_win;
        pulse_frame_start();
        wait_frame_done(200, "rst");
        @(negedge clock);
        checks++; if (hs_a - h0 != 24 || win_count_a !== 20'd24) begin errors++; $display("FAIL rst_windows got %0d/%0d want 24/24", hs_a - h0, win_count_a); end
        checks++; if (order_errors(q0) != 0 || bad_win - bw0 != 0) begin errors++; $display("FAIL rst_content got order=%0d content=%0d want 0 0", order_errors(q0), bad_win - bw0); end
    endtask

    task automatic test_random_gaps();
        int h0 = hs_a, q0 = qx_a.size(), bw0 = bad_win, bb0 = bad_buf, fa0 = fd_cnt_a;
        bit done = 1'b0;
        wr = 1'b1; pv = 1'b0;
        pulse_frame_start();
        for (int n = 0; n < 2000 && !done; n++) begin
            tick();
            pv = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            if (fd_a) done = 1'b1;
        end
        pv = 1'b0; wr = 1'b1;
        checks++; if (!done) begin errors++; $display("FAIL rnd_timeout got no frame_done want frame_done within 2000 cycles"); end
        repeat (2) @(negedge clock);
        checks++; if (hs_a - h0 != 24 || win_count_a !== 20'd24) begin errors++; $display("FAIL rnd_windows got %0d/%0d want 24/24", hs_a - h0, win_count_a); end
        checks++; if (order_errors(q0) != 0) begin errors++; $display("FAIL rnd_order got %0d bad want 0", order_errors(q0)); end
        checks++; if (bad_win - bw0 != 0) begin errors++; $display("FAIL rnd_content got %0d bad want 0", bad_win - bw0); end
        checks++; if (bad_buf - bb0 != 0) begin errors++; $display("FAIL rnd_buf_port got %0d bad want 0", bad_buf - bb0); end
        checks++; if (frame_acc != IMC * IMR || fd_cnt_a - fa0 != 1) begin errors++; $display("FAIL rnd_frame got acc=%0d done=%0d want %0d 1", frame_acc, fd_cnt_a - fa0, IMC * IMR); end
    endtask

    initial begin
        test_reset();
        test_stride_one_two();
        test_backpressure();
        test_ignored_inputs();
        test_reset_midframe();
        test_random_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion want finish before 2ms");
        $fatal(1);
    end
endmodule

// File: doc/window_scan_controller.md
WINDOW_SCAN_CONTROLLER -- requirements
Module: window_scan_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- imCol, 1024, image width in pixels.
- imRow, 768, image height in lines.
- winRow, 24, window height.
- winCol, 24, window width.
- bitwidth, 8, pixel width.
- step, 1, window stride in x and y (>=1).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous, active-high.
- frame_start, in, 1, one-cycle start-of-frame pulse.
- pixel_valid, in, 1, upstream pixel present.
- pixel_data, in, bitwidth, upstream pixel.
- pixel_ready, out, 1, pixel accepted this cycle when high with pixel_valid.
- buf_enable, out, 1, shift enable to window buffer.
- buf_data, out, bitwidth, pixel to window buffer.
- win_ready, in, 1, downstream consumes window.
- win_valid, out, 1, window buffer output is a scheduled window.
- win_x, out, log2(imCol), window top-left column.
- win_y, out, log2(imRow), window top-left row.
- win_count, out, 20, windows issued this frame.
- busy, out, 1, state != IDLE.
- frame_done, out, 1, one-cycle end-of-frame pulse.

Function
REQ-003 FSM states SHALL be IDLE, FILL, SCAN, DRAIN.
- IDLE->FILL on frame_start.
- FILL->SCAN on acceptance of pixel (row winRow-2, col imCol-1).
- SCAN->DRAIN on acceptance of pixel (imRow-1, imCol-1).
- DRAIN->IDLE when win_valid==0, or on the cycle win_valid&&win_ready.

REQ-004 Accept SHALL be pixel_valid && pixel_ready.
- pixel_ready = (state==FILL || state==SCAN) && !(win_valid && !win_ready).
- Combinational; no registered skid.

REQ-005 buf_enable SHALL equal accept (combinational); buf_data SHALL equal pixel_data unregistered.

REQ-006 Position counters col and row SHALL advance once per accept.
- col wraps imCol-1 -> 0, incrementing row.
- Both counters clear on IDLE->FILL.

REQ-007 Stride counters sx and sy SHALL track position modulo step.
- sx = (col-(winCol-1)) mod step; cleared when col==winCol-1.
- sy = (row-(winRow-1)) mod step; cleared when row==winRow-1.
- Implemented as counters; no divider.

REQ-008 A scheduled window SHALL be an accept at (row r, col c) with r>=winRow-1, c>=winCol-1, sx==0, sy==0.
- On the accept edge: win_valid<=1, win_x<=c-(winCol-1), win_y<=r-(winRow-1), win_count<=win_count+1.
- win_valid therefore rises one cycle after buf_enable, aligned with updated buffer contents.

REQ-009 win_valid SHALL clear on win_valid&&win_ready unless a new window is scheduled on the same edge; set has priority.

REQ-010 While win_valid && !win_ready:
- no accept occurs, so buffer contents are frozen.
- win_x, win_y and win_valid SHALL hold stable.

REQ-011 frame_start SHALL be ignored outside IDLE.
- pixel_valid SHALL be ignored in IDLE and DRAIN (pixel_ready low).

REQ-012 frame_done SHALL pulse for exactly one cycle on the DRAIN->IDLE transition.
- win_count holds its value until the next IDLE->FILL, then clears.

REQ-013 Windows per frame SHALL be ceil((imCol-winCol+1)/step) * ceil((imRow-winRow+1)/step).
- win_count wraps modulo 2^20.

Reset
REQ-014 Reset SHALL act on the rising edge and take priority over all other inputs, including mid-frame.
- state<=IDLE.
- col, row, sx, sy <= 0.
- win_valid, frame_done, win_count, win_x, win_y <= 0.
- Consequently pixel_ready, buf_enable and busy are 0.

REQ-015 Reset SHALL NOT attempt to clear the window buffer itself; the buffer shares the same reset.

Verification
REQ-016 The bench SHALL cover the following directed scenarios.
- Scenario 1: imCol=8, imRow=6, winRow=winCol=3, step=1, continuous pixel_valid, win_ready=1 -> 24 win_valid cycles; first (win_x,win_y)=(0,0) one cycle after the 19th accept; last (5,3); frame_done once; win_count=24.
- Scenario 2: same parameters, step=2 -> 6 windows at x in {0,2,4}, y in {0,2}; win_count=6.
- Scenario 3: step=1, win_ready held low 5 cycles at the first window -> pixel_ready=0 and buf_enable=0 for those 5 cycles; win_x, win_y and buffer output stable; no window lost; final win_count=24.
- Scenario 4: frame_start pulsed during SCAN and pixel_valid asserted in IDLE -> no state or count change; pixel_ready=0 in IDLE.
- Scenario 5: reset asserted after 30 accepts -> next cycle state IDLE, busy=0, win_valid=0, win_count=0; a following frame_start yields a full correct 24-window frame.
- Scenario 6: random pixel_valid/win_ready gaps against a reference-model window buffer -> every win_valid window matches the model at (win_x,win_y); no buf_enable without accept.
